// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and sizes for the 4x4 keypad scanner.
// Revision    : 1.0
// ============================================================================
package keypad_pkg;

    localparam int NUM_COL = 4;
    localparam int NUM_ROW = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } frame_class_t;

endpackage
`default_nettype wire

// File: rtl/keypad_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer, resets to all-ones (idle pulled-up rows).
// Revision    : 1.0
// ============================================================================
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner with frame-based debounce.
// Revision    : 1.0
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 10000,
    parameter int DEBOUNCE = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB       = 4'(DEBOUNCE);

    logic [NUM_ROW-1:0] row_s;
    logic [CNT_W-1:0]   slot_q;
    logic [1:0]         col_q;
    logic [3:0]         col_out_q;
    logic [15:0]        frame_q;
    logic [15:0]        frame_cur;
    logic               sample;
    logic               frame_end;
    logic [4:0]         n_low;
    logic [3:0]         cand;
    frame_class_t       fclass;

    state_t     state_q, state_d;
    logic [3:0] cand_q,  cand_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] code_q,  code_d;
    logic       valid_q, valid_d;
    logic       held_q,  held_d;

    sync2 #(.WIDTH(NUM_ROW)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (row_in),
        .q_o   (row_s)
    );

    assign sample    = (slot_q == SLOT_LAST);
    assign frame_end = sample && (col_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q    <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
            frame_q   <= '0;
        end else begin
            if (sample) begin
                slot_q    <= '0;
                col_q     <= col_q + 2'd1;
                col_out_q <= ~(4'b0001 << (col_q + 2'd1));
                frame_q   <= frame_cur;
            end else begin
                slot_q <= slot_q + 1'b1;
            end
        end
    end

    // Frame image holds 1 = key down; the current column is merged in so the
    // classifier sees column 3 on the very cycle it is sampled.
    always_comb begin
        frame_cur = frame_q;
        frame_cur[{col_q, 2'b00} +: NUM_ROW] = ~row_s;
    end

    always_comb begin
        n_low = '0;
        cand  = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_cur[i]) begin
                n_low = n_low + 5'd1;
                cand  = 4'(i);
            end
        end
        if (n_low == 5'd0)      fclass = NONE;
        else if (n_low == 5'd1) fclass = ONE;
        else                    fclass = MULTI;
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (fclass == ONE) begin
                        cand_d = cand;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            code_d  = cand;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = PRESSED;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (fclass == ONE && cand == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = PRESSED;
                        end
                    end else if (fclass == ONE) begin
                        cand_d = cand;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (fclass == NONE) begin
                        if (DEB == 4'd1) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (fclass == NONE) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan
// Description : Scoreboard bench for keypad_scan with a modelled key matrix.
// Revision    : 1.0
// ============================================================================
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Pressed key k pulls row k%4 low while its column k/4 is strobed.
    always_comb begin
        row_in = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] && !col_out[k / 4]) row_in[k % 4] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse key_code=%0d expected no pulse", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_code key_code=%0d held=%b expected code=%0d held=1",
                             key_code, key_held, mon_exp);
                end
            end
            if (prev_valid) begin
                checks++;
                errors++;
                $display("FAIL pulse_width key_valid high 2 cycles, expected 1");
            end
        end
        prev_valid = key_valid;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic align();
        int n = 0;
        @(negedge clk);
        while (col_out != 4'b0111 && n < 64) begin @(negedge clk); n++; end
        while (col_out == 4'b0111 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL align_timeout col_out=%b expected frame start", col_out);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_col;
        keys  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_col_out",   {12'h0, col_out},  16'h000E);
        chk("reset_key_code",  {12'h0, key_code}, 16'h0000);
        chk("reset_key_valid", {15'h0, key_valid}, 16'h0000);
        chk("reset_key_held",  {15'h0, key_held}, 16'h0000);
        reset = 1'b0;

        // Column strobe rotation, one column per SCAN_DIV cycles.
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            chk("col_rotation", {12'h0, col_out}, {12'h0, exp_col});
            @(negedge clk);
        end
        wait_frames(20);

        // Key 9 (col 2, row 1) held six frames.
        align();
        exp_q.push_back(4'd9);
        keys = 16'h0200;
        wait_frames(6);
        chk("press9_held", {15'h0, key_held}, 16'h0001);
        chk("press9_code", {12'h0, key_code}, 16'h0009);
        chk("press9_seen", 16'(exp_q.size()), 16'h0000);

        // Release: held survives two empty frames, clears on the third.
        keys = '0;
        wait_frames(2);
        chk("release_2frames_held", {15'h0, key_held}, 16'h0001);
        wait_frames(1);
        chk("release_3frames_held", {15'h0, key_held}, 16'h0000);
        chk("release_code_kept",    {12'h0, key_code}, 16'h0009);

        // Two-frame glitch never reaches DEBOUNCE.
        keys = 16'h0200;
        wait_frames(2);
        keys = '0;
        chk("glitch_held", {15'h0, key_held}, 16'h0000);
        wait_frames(3);
        chk("glitch_held_after", {15'h0, key_held}, 16'h0000);

        // Hold 9, add key 0: no second event until full release.
        exp_q.push_back(4'd9);
        keys = 16'h0200;
        wait_frames(5);
        keys = 16'h0201;
        wait_frames(4);
        chk("multi_held", {15'h0, key_held}, 16'h0001);
        chk("multi_code", {12'h0, key_code}, 16'h0009);
        keys = '0;
        wait_frames(4);
        chk("multi_release_held", {15'h0, key_held}, 16'h0000);
        exp_q.push_back(4'd0);
        keys = 16'h0001;
        wait_frames(5);
        chk("press0_code", {12'h0, key_code}, 16'h0000);
        chk("press0_held", {15'h0, key_held}, 16'h0001);
        chk("press0_seen", 16'(exp_q.size()), 16'h0000);
        keys = '0;
        wait_frames(4);

        // Reset mid-debounce, then a clean three-frame press of key 6.
        keys = 16'h0040;
        wait_frames(2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        keys  = '0;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_col_out", {12'h0, col_out}, 16'h000E);
        chk("midreset_held",    {15'h0, key_held}, 16'h0000);
        align();
        exp_q.push_back(4'd6);
        keys = 16'h0040;
        wait_frames(3);
        repeat (2) @(negedge clk);
        chk("press6_held", {15'h0, key_held}, 16'h0001);
        chk("press6_code", {12'h0, key_code}, 16'h0006);
        keys = '0;
        wait_frames(4);

        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad: drives active-low column strobes, reads the four row inputs, debounces, and reports one key code per press. It is the input-side counterpart of the LED pattern/scroll outputs on the lab board. It sits between the keypad header pins and the lab's user logic, which consumes `key_code`/`key_valid`.

## Interface

- `SCAN_DIV`, default 10000: clk cycles per column slot (1 ms at 10 MHz); legal range ≥ 4.
- `DEBOUNCE`, default 5: consecutive identical frames required to accept a press or a release; legal range 1–15.
- `clk`  input  1  system clock, board 10 MHz.
- `reset`  input  1  synchronous, active-high; all state is cleared on the clk edge where `reset` = 1.
- `row_in`  input  4  keypad rows, active-low (pulled up off-chip), asynchronous to clk.
- `col_out`  output  4  column strobes, active-low, exactly one bit low at all times.
- `key_code`  output  4  code of the accepted key = col*4 + row; holds its value until the next accepted press.
- `key_valid`  output  1  1-cycle pulse when a press is accepted.
- `key_held`  output  1  high from acceptance until the release is accepted.

## Operation

- `row_in` passes through a 2-flop synchronizer; all logic uses the synchronized rows `row_s`.
- Slot counter: 0..SCAN_DIV-1. Column index `col` = 0..3 advances when the counter wraps, and wraps 3→0.
- `col_out` = ~(1 << col). It is registered and changes on the same edge as `col`.
- Sample point: slot count == SCAN_DIV-1. Capture `row_s` for the current column into a 16-bit frame image.
- Frame end: sample point of col 3. Classify the frame:
  - NONE: no bit low.
  - ONE: exactly one bit low; candidate = col*4 + row.
  - MULTI: two or more bits low. MULTI is treated as NONE for press detection and as "not released" in PRESSED/REL_DB.
- FSM, evaluated once per frame end (`match_cnt` is 4 bits):
  - IDLE: on ONE, latch the candidate, set `match_cnt`=1, go to PRESS_DB. If DEBOUNCE=1, accept immediately.
  - PRESS_DB: on ONE with the same candidate, increment `match_cnt`. When it reaches DEBOUNCE, accept and go to PRESSED. On a different ONE, restart with the new candidate at count 1. On NONE or MULTI, go to IDLE.
  - PRESSED: on NONE, set `match_cnt`=1 and go to REL_DB (with DEBOUNCE=1, go directly to IDLE). Any other result stays in PRESSED.
  - REL_DB: on NONE, increment the count; at DEBOUNCE, go to IDLE. Any non-NONE result returns to PRESSED.
- Accept: `key_code` ← candidate, `key_valid` pulses, `key_held` ← 1.
- `key_held` clears on entry to IDLE from REL_DB.
- A second key pressed while one is held yields no new event; it is reported only after the full release.

## Timing

- Reset values: `col_out`=4'b1110, `key_code`=4'h0, `key_valid`=0, `key_held`=0, state IDLE, all counters and the frame image 0.
- Frame length: 4*SCAN_DIV cycles.
- Rows settle for SCAN_DIV-1 cycles before sampling. Synchronizer latency is 2 cycles, which is covered by SCAN_DIV ≥ 4.
- Press latency: `key_valid` is asserted 1 cycle after the DEBOUNCE-th matching frame-end sample. Worst case from a stable press: (DEBOUNCE+1)*4*SCAN_DIV + 3 cycles.
- `key_valid` never lasts more than 1 cycle. At most one pulse per DEBOUNCE frames.
- Reset asserted mid-frame or mid-debounce: on the next edge, all state returns to reset values. Scanning restarts at col 0, slot 0 on the first cycle after `reset` deasserts.

## Structure

- Shared package `keypad_pkg`:
  - state enum {IDLE, PRESS_DB, PRESSED, REL_DB}
  - localparams NUM_COL=4, NUM_ROW=4
  - frame-class enum {NONE, ONE, MULTI}
- Sub-module `sync2`: 2-flop synchronizer with parameterized width (4 here), reset to all-ones.
- Everything else lives in `keypad_scan`: slot/column counters, frame capture and classifier, FSM, output registers.

## Test plan

Use SCAN_DIV=4 and DEBOUNCE=3 (16-cycle frame).

1. Reset with `row_in`=4'hF: `col_out` is 4'b1110 and cycles 1110→1101→1011→0111 every 4 cycles. No `key_valid` over 20 frames.
2. Model key (col 2, row 1) held for 6 frames, i.e. row1 low only while col_out[2]=0: exactly one `key_valid` pulse, `key_code`=4'd9, `key_held`=1.
3. Glitch: key 9 held for 2 frames, then released: no `key_valid`, `key_held` stays 0.
4. Release after (2): `key_held` falls after the 3rd empty frame; `key_code` stays 9.
5. Hold key 9, then add key 4'd0 (col 0, row 0): no new pulse. Release both, then press 0 alone: one pulse, `key_code`=0.
6. Assert `reset` for 1 cycle while in PRESS_DB: the state returns to IDLE and `col_out`=4'b1110. A subsequent 3-frame press yields exactly one pulse.
